uart_feedback_decoder: RTL and testbench

- Receive-side counterpart of the round-robin UART sender.
- Takes bytes from the UART RX core and checks that they arrive in the 3-byte frame order: game state, target machine, machine feedback.
- Stages each payload and commits all three atomically once a frame completes.
- Drives the game logic with registered feedback values, per-field change strobes, error reporting and a link-alive watchdog.

---
 rtl/uart_feedback_decoder.sv | 178 +++++++++++++++++
 tb/tb_uart_feedback_decoder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_feedback_decoder.sv
// uart_feedback_decoder
// Receive-side frame decoder for the round-robin UART feedback link.
// Bytes carry a 2-bit tag in [1:0] and a 6-bit payload in [7:2]. A frame
// is game state (tag 01), target machine (tag 10), machine feedback (tag 11).
// Payloads are staged, then committed together when the frame completes.
// Tag 00 is idle filler: it only keeps the link watchdog alive.
//
// Ports:
//   uart_clk          sole clock, rising edge
//   rst               asynchronous active-high reset
//   rx_data[7:0]      received byte, rx_valid one-cycle strobe
//   game_state, target_machine, machine_feedback  committed payloads
//   game_state_upd, target_upd, feedback_upd      change pulses on commit
//   frame_done        pulse on commit
//   frame_error       pulse on out-of-order tag
//   error_count       saturating frame_error count
//   link_alive        high while bytes keep arriving within TIMEOUT_CYCLES
//
// state   | meaning
// WAIT_GS | expecting game-state byte (start of frame)
// WAIT_TM | game state staged, expecting target-machine byte
// WAIT_FB | gs/tm staged, expecting machine-feedback byte (commit)
module uart_feedback_decoder #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TIMEOUT_W      = 20
) (
  input  logic       uart_clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [5:0] game_state,
  output logic [5:0] target_machine,
  output logic [5:0] machine_feedback,
  output logic       game_state_upd,
  output logic       target_upd,
  output logic       feedback_upd,
  output logic       frame_done,
  output logic       frame_error,
  output logic [7:0] error_count,
  output logic       link_alive
);

  typedef enum logic [1:0] {
    WAIT_GS = 2'd0,
    WAIT_TM = 2'd1,
    WAIT_FB = 2'd2
  } state_t;

  localparam logic [TIMEOUT_W-1:0] TO_MAX = TIMEOUT_W'(TIMEOUT_CYCLES);

  state_t                 state_q;
  logic [5:0]             gs_stg_q;
  logic [5:0]             tm_stg_q;
  logic [TIMEOUT_W-1:0]   cnt_q;
  logic [TIMEOUT_W-1:0]   cnt_d;
  logic                   timeout_hit;
  logic                   tag_err;
  logic [1:0]             tag;
  logic [5:0]             payload;

  assign tag     = rx_data[1:0];
  assign payload = rx_data[7:2];

  // Watchdog: cleared by any byte, otherwise counts up and parks at TO_MAX.
  // A byte in the expiry cycle wins because timeout_hit requires !rx_valid.
  always_comb begin
    cnt_d = cnt_q;
    if (rx_valid) begin
      cnt_d = '0;
    end else if (cnt_q != TO_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
    timeout_hit = !rx_valid && (cnt_d == TO_MAX);
  end

  // Any non-idle tag other than the one the current state expects.
  always_comb begin
    tag_err = 1'b0;
    if (rx_valid && tag != 2'b00) begin
      case (state_q)
        WAIT_GS: tag_err = (tag != 2'b01);
        WAIT_TM: tag_err = (tag != 2'b10);
        WAIT_FB: tag_err = (tag != 2'b11);
        default: tag_err = 1'b1;
      endcase
    end
  end

  always_ff @(posedge uart_clk or posedge rst) begin
    if (rst) begin
      state_q          <= WAIT_GS;
      gs_stg_q         <= '0;
      tm_stg_q         <= '0;
      cnt_q            <= '0;
      game_state       <= '0;
      target_machine   <= '0;
      machine_feedback <= '0;
      game_state_upd   <= 1'b0;
      target_upd       <= 1'b0;
      feedback_upd     <= 1'b0;
      frame_done       <= 1'b0;
      frame_error      <= 1'b0;
      error_count      <= '0;
      link_alive       <= 1'b0;
    end else begin
      game_state_upd <= 1'b0;
      target_upd     <= 1'b0;
      feedback_upd   <= 1'b0;
      frame_done     <= 1'b0;
      frame_error    <= 1'b0;
      cnt_q          <= cnt_d;

      if (rx_valid) begin
        link_alive <= 1'b1;
      end

      if (tag_err) begin
        frame_error <= 1'b1;
        if (error_count != 8'hFF) begin
          error_count <= error_count + 8'd1;
        end
      end

      if (timeout_hit) begin
        // Committed outputs are deliberately left untouched.
        link_alive <= 1'b0;
        state_q    <= WAIT_GS;
        gs_stg_q   <= '0;
        tm_stg_q   <= '0;
      end else if (rx_valid && tag != 2'b00) begin
        case (state_q)
          WAIT_GS: begin
            if (tag == 2'b01) begin
              gs_stg_q <= payload;
              state_q  <= WAIT_TM;
            end
          end
          WAIT_TM: begin
            if (tag == 2'b10) begin
              tm_stg_q <= payload;
              state_q  <= WAIT_FB;
            end else if (tag == 2'b01) begin
              gs_stg_q <= payload;
              state_q  <= WAIT_TM;
            end else begin
              gs_stg_q <= '0;
              tm_stg_q <= '0;
              state_q  <= WAIT_GS;
            end
          end
          WAIT_FB: begin
            if (tag == 2'b11) begin
              game_state       <= gs_stg_q;
              target_machine   <= tm_stg_q;
              machine_feedback <= payload;
              game_state_upd   <= (gs_stg_q != game_state);
              target_upd       <= (tm_stg_q != target_machine);
              feedback_upd     <= (payload != machine_feedback);
              frame_done       <= 1'b1;
              state_q          <= WAIT_GS;
            end else if (tag == 2'b01) begin
              // A new game-state byte resynchronises onto a fresh frame.
              gs_stg_q <= payload;
              tm_stg_q <= '0;
              state_q  <= WAIT_TM;
            end else begin
              gs_stg_q <= '0;
              tm_stg_q <= '0;
              state_q  <= WAIT_GS;
            end
          end
          default: state_q <= WAIT_GS;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_feedback_decoder.sv
module tb_uart_feedback_decoder;
  localparam int TC = 16;

  logic       uart_clk = 1'b0;
  logic       rst      = 1'b1;
  logic [7:0] rx_data  = 8'h00;
  logic       rx_valid = 1'b0;
  logic [5:0] game_state, target_machine, machine_feedback;
  logic       game_state_upd, target_upd, feedback_upd;
  logic       frame_done, frame_error, link_alive;
  logic [7:0] error_count;

  uart_feedback_decoder #(.TIMEOUT_CYCLES(TC), .TIMEOUT_W(5)) dut (
    .uart_clk         (uart_clk),
    .rst              (rst),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .game_state       (game_state),
    .target_machine   (target_machine),
    .machine_feedback (machine_feedback),
    .game_state_upd   (game_state_upd),
    .target_upd       (target_upd),
    .feedback_upd     (feedback_upd),
    .frame_done       (frame_done),
    .frame_error      (frame_error),
    .error_count      (error_count),
    .link_alive       (link_alive)
  );

  always #5 uart_clk = ~uart_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: frame position counts how many in-order payloads are
  // collected (0..2); idle counts consecutive byte-free cycles.
  int         m_pos, m_idle, m_ec;
  logic [5:0] m_sgs, m_stm, m_gs, m_tm, m_fb;
  logic       m_gsu, m_tmu, m_fbu, m_done, m_err, m_alive;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_idle = 0; m_ec = 0;
    m_sgs = 0; m_stm = 0; m_gs = 0; m_tm = 0; m_fb = 0;
    m_gsu = 0; m_tmu = 0; m_fbu = 0; m_done = 0; m_err = 0; m_alive = 0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] d);
    int         t;
    logic [5:0] p;
    t = int'(d[1:0]);
    p = d[7:2];
    m_gsu = 0; m_tmu = 0; m_fbu = 0; m_done = 0; m_err = 0;
    if (v) begin
      m_idle  = 0;
      m_alive = 1;
      if (t == 0) begin
      end else if (t == m_pos + 1) begin
        if (m_pos == 0) m_sgs = p;
        else if (m_pos == 1) m_stm = p;
        else begin
          m_gsu  = (m_sgs != m_gs);
          m_tmu  = (m_stm != m_tm);
          m_fbu  = (p != m_fb);
          m_gs   = m_sgs;
          m_tm   = m_stm;
          m_fb   = p;
          m_done = 1;
        end
        m_pos = (m_pos + 1) % 3;
      end else begin
        m_err = 1;
        if (m_ec < 255) m_ec++;
        if (t == 1) begin
          m_sgs = p;
          m_pos = 1;
        end else begin
          m_pos = 0;
        end
      end
    end else begin
      if (m_idle < TC) m_idle++;
      if (m_idle == TC) begin
        m_alive = 0;
        m_pos   = 0;
      end
    end
  endtask

  task automatic check_all();
    check_val("game_state",       32'(game_state),       32'(m_gs));
    check_val("target_machine",   32'(target_machine),   32'(m_tm));
    check_val("machine_feedback", 32'(machine_feedback), 32'(m_fb));
    check_val("game_state_upd",   32'(game_state_upd),   32'(m_gsu));
    check_val("target_upd",       32'(target_upd),       32'(m_tmu));
    check_val("feedback_upd",     32'(feedback_upd),     32'(m_fbu));
    check_val("frame_done",       32'(frame_done),       32'(m_done));
    check_val("frame_error",      32'(frame_error),      32'(m_err));
    check_val("error_count",      32'(error_count),      32'(m_ec));
    check_val("link_alive",       32'(link_alive),       32'(m_alive));
  endtask

  task automatic cycle(input logic v, input logic [7:0] d);
    @(negedge uart_clk);
    rx_valid = v;
    rx_data  = d;
    @(posedge uart_clk);
    model_step(v, d);
    #1;
    check_all();
  endtask

  task automatic send(input logic [7:0] d);
    cycle(1'b1, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'($urandom));
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send(a); send(b); send(c);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge uart_clk);
    #1;
    check_all();
    @(negedge uart_clk);
    rst = 1'b0;

    // In-order frame, all fields change.
    send_frame(8'h15, 8'h0E, 8'hAB);
    check_val("s1_gs_const", 32'(game_state), 32'h05);
    check_val("s1_tm_const", 32'(target_machine), 32'h03);
    check_val("s1_fb_const", 32'(machine_feedback), 32'h2A);
    check_val("s1_upd_all", 32'({game_state_upd, target_upd, feedback_upd, frame_done}), 32'hF);
    idle(1);

    // Identical repeat, then only game state changes.
    send_frame(8'h15, 8'h0E, 8'hAB);
    check_val("s2_repeat_upd", 32'({game_state_upd, target_upd, feedback_upd, frame_done}), 32'h1);
    send_frame(8'h19, 8'h0E, 8'hAB);
    check_val("s2_gs_only", 32'({game_state_upd, target_upd, feedback_upd, frame_done}), 32'h9);
    check_val("s2_gs_const", 32'(game_state), 32'h06);

    // Out-of-order feedback byte after game state.
    send(8'h15);
    send(8'hAB);
    check_val("s3_err_const", 32'({frame_error, error_count}), 32'h101);
    send_frame(8'h15, 8'h0E, 8'hAB);

    // Idle filler inside a frame.
    send(8'h15); send(8'h00); send(8'h0E); send(8'h00); send(8'hAB);
    check_val("s4_done_const", 32'(frame_done), 32'h1);

    // Watchdog expiry drops staging.
    send(8'h15);
    idle(TC);
    check_val("s5_dead_const", 32'(link_alive), 32'h0);
    send(8'h0E);
    check_val("s5_err_const", 32'(frame_error), 32'h1);
    send_frame(8'h15, 8'h0E, 8'hAB);
    check_val("s5_alive_const", 32'(link_alive), 32'h1);

    // Byte landing exactly on the expiry cycle keeps the link alive.
    send(8'h15);
    idle(TC - 1);
    send(8'h0E);
    send(8'hAB);

    // Randomized traffic biased toward well-formed frames.
    for (int k = 0; k < 500; k++) begin
      int mode;
      mode = $urandom_range(0, 9);
      if (mode <= 5) send({6'($urandom), 2'(m_pos + 1)});
      else if (mode <= 7) send(8'($urandom));
      else if (mode == 8) idle($urandom_range(1, 3));
      else idle($urandom_range(10, 20));
    end

    // Error counter saturation.
    for (int k = 0; k < 300; k++) send(8'hAB);
    check_val("s6_sat_const", 32'(error_count), 32'hFF);

    // Make committed outputs nonzero, then reset mid-frame.
    send_frame(8'h15, 8'h0E, 8'hAB);
    send(8'h19);
    send(8'h0E);
    @(negedge uart_clk);
    rx_valid = 1'b1;
    rx_data  = 8'hAB;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge uart_clk);
    #1;
    check_all();
    @(negedge uart_clk);
    rx_valid = 1'b0;
    rst      = 1'b0;
    idle(3);
    send_frame(8'h15, 8'h0E, 8'hAB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
